// File: rtl/regfile_stage_controller_if.sv
// Instruction, memory and write-back bundle between the TinyCPU sequencer and its datapath.
// The master drives instructions and memory responses. The slave is the regfile/sequencer.
interface regfile_stage_controller_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [4:0]            instr_type;
    logic [REG_AW-1:0]     rd;
    logic [REG_AW-1:0]     rs0;
    logic [REG_AW-1:0]     rs1;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] alu_operand_0;
    logic [DATA_WIDTH-1:0] alu_operand_1;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_read_req;
    logic                  mem_read_valid;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_write_req;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  wb_en;
    logic [REG_AW-1:0]     wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [2:0]            stage;
    logic                  done;

    modport master (
        output instr_valid, instr_type, rd, rs0, rs1, imm, alu_result, mem_read_valid,
               mem_read_data,
        input  instr_ready, alu_operand_0, alu_operand_1, mem_addr, mem_read_req, mem_write_req,
               mem_write_data, wb_en, wb_addr, wb_data, stage, done
    );

    modport slave (
        input  instr_valid, instr_type, rd, rs0, rs1, imm, alu_result, mem_read_valid,
               mem_read_data,
        output instr_ready, alu_operand_0, alu_operand_1, mem_addr, mem_read_req, mem_write_req,
               mem_write_data, wb_en, wb_addr, wb_data, stage, done
    );
endinterface

// File: rtl/regfile_stage_controller.sv
// Register file with a five-stage instruction sequencer (fetch, mem-read, reg-update,
// mem-write, pc-update) for the TinyCPU datapath. It stalls in mem-read until load data returns.
module regfile_stage_controller #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    regfile_stage_controller_if.slave   io_bus
);
    localparam int unsigned REG_AW = $clog2(NUM_REGS);

    localparam logic [4:0] TypeLoadImm = 5'd1;
    localparam logic [4:0] TypeLoad    = 5'd2;
    localparam logic [4:0] TypeStore   = 5'd3;
    localparam logic [4:0] TypeAlu     = 5'd5;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StMemRead   = 3'd1,
        StRegUpdate = 3'd2,
        StMemWrite  = 3'd3,
        StPcUpdate  = 3'd4
    } stage_e;

    stage_e                r_stage;
    logic [4:0]            r_type;
    logic [REG_AW-1:0]     r_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_op0;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_load_buf;
    logic                  r_wb_en;
    logic                  r_mem_read_req;
    logic                  r_mem_write_req;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [DATA_WIDTH-1:0] w_rs0_data;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_writes_reg;
    logic                  w_drop_write;

    always_comb begin
        w_rs0_data = r_regs[io_bus.rs0];
        w_rs1_data = r_regs[io_bus.rs1];
        if (ZERO_REG != 0 && io_bus.rs0 == '0) w_rs0_data = '0;
        if (ZERO_REG != 0 && io_bus.rs1 == '0) w_rs1_data = '0;
    end

    assign w_writes_reg = (r_type == TypeLoadImm) || (r_type == TypeLoad) || (r_type == TypeAlu);
    assign w_drop_write = (ZERO_REG != 0) && (r_rd == '0);

    // r_wb_en is only ever high during REG_UPDATE, so it doubles as the stage qualifier here.
    always_comb begin
        w_wb_data = '0;
        if (r_wb_en) begin
            case (r_type)
                TypeLoadImm: w_wb_data = r_imm;
                TypeLoad:    w_wb_data = r_load_buf;
                default:     w_wb_data = io_bus.alu_result;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage         <= StFetch;
            r_type          <= '0;
            r_rd            <= '0;
            r_imm           <= '0;
            r_op0           <= '0;
            r_op1           <= '0;
            r_load_buf      <= '0;
            r_wb_en         <= 1'b0;
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_done          <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_stage)
                StFetch: begin
                    if (io_bus.instr_valid) begin
                        r_type         <= io_bus.instr_type;
                        r_rd           <= io_bus.rd;
                        r_imm          <= io_bus.imm;
                        r_op0          <= w_rs0_data;
                        r_op1          <= w_rs1_data;
                        r_mem_read_req <= (io_bus.instr_type == TypeLoad);
                        r_stage        <= StMemRead;
                    end
                end
                StMemRead: begin
                    if (r_type != TypeLoad) begin
                        r_wb_en <= w_writes_reg;
                        r_stage <= StRegUpdate;
                    end else if (io_bus.mem_read_valid) begin
                        r_load_buf     <= io_bus.mem_read_data;
                        r_mem_read_req <= 1'b0;
                        r_wb_en        <= 1'b1;
                        r_stage        <= StRegUpdate;
                    end
                end
                StRegUpdate: begin
                    if (r_wb_en && !w_drop_write) begin
                        r_regs[r_rd] <= w_wb_data;
                    end
                    r_wb_en         <= 1'b0;
                    r_mem_write_req <= (r_type == TypeStore);
                    r_stage         <= StMemWrite;
                end
                StMemWrite: begin
                    r_mem_write_req <= 1'b0;
                    r_done          <= 1'b1;
                    r_stage         <= StPcUpdate;
                end
                StPcUpdate: begin
                    r_done  <= 1'b0;
                    r_stage <= StFetch;
                end
                default: begin
                    r_wb_en         <= 1'b0;
                    r_mem_read_req  <= 1'b0;
                    r_mem_write_req <= 1'b0;
                    r_done          <= 1'b0;
                    r_stage         <= StFetch;
                end
            endcase
        end
    end

    assign io_bus.instr_ready    = (r_stage == StFetch);
    assign io_bus.stage          = r_stage;
    assign io_bus.alu_operand_0  = r_op0;
    assign io_bus.alu_operand_1  = r_op1;
    assign io_bus.mem_addr       = r_op0;
    assign io_bus.mem_write_data = r_op1;
    assign io_bus.mem_read_req   = r_mem_read_req;
    assign io_bus.mem_write_req  = r_mem_write_req;
    assign io_bus.wb_en          = r_wb_en;
    assign io_bus.wb_addr        = r_wb_en ? r_rd : '0;
    assign io_bus.wb_data        = w_wb_data;
    assign io_bus.done           = r_done;
endmodule

// File: tb/tb_regfile_stage_controller.sv
// Scoreboard bench for regfile_stage_controller: stimulus queues expected write-backs and
// stores, and a negedge monitor pops and compares them whenever the DUT strobes wb_en or mem_write_req.
module tb_regfile_stage_controller;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_stage_controller_if #(.DATA_WIDTH(DW), .REG_AW(AW)) bus ();

    regfile_stage_controller #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (32),
        .ZERO_REG  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW+DW-1:0] wb_q [$];
    logic [2*DW-1:0]  st_q [$];
    logic [AW+DW-1:0] wb_e;
    logic [2*DW-1:0]  st_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_en === 1'b1) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_wb: got wb_en=1 addr %0d, expected none", bus.wb_addr);
                end else begin
                    wb_e = wb_q.pop_front();
                    check("wb_addr", 32'(bus.wb_addr), 32'(wb_e[AW+DW-1:DW]));
                    check("wb_data", bus.wb_data, wb_e[DW-1:0]);
                end
            end
            if (bus.mem_write_req === 1'b1) begin
                if (st_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_store: got mem_write_req=1, expected none");
                end else begin
                    st_e = st_q.pop_front();
                    check("st_addr", bus.mem_addr, st_e[2*DW-1:DW]);
                    check("st_data", bus.mem_write_data, st_e[DW-1:0]);
                end
            end
        end
    end

    task automatic run_instr(input logic [4:0] typ, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                             input logic [DW-1:0] imm, input logic [DW-1:0] alu,
                             input logic [DW-1:0] exp0, input logic [DW-1:0] exp1,
                             input int exp_wb, input int exp_st, input int nread,
                             input logic [DW-1:0] rdata, input int exp_done);
        int cyc;
        @(negedge clk);
        check("instr_ready", 32'(bus.instr_ready), 32'd1);
        check("stage_fetch", 32'(bus.stage), 32'd0);
        bus.instr_type  = typ;
        bus.rd          = rd;
        bus.rs0         = rs0;
        bus.rs1         = rs1;
        bus.imm         = imm;
        bus.alu_result  = alu;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        cyc = 1;
        // Scramble fields so only the latched copies can produce the right answers.
        bus.instr_valid = 1'b0;
        bus.rd          = '1;
        bus.rs0         = '1;
        bus.rs1         = '1;
        bus.imm         = '1;
        check("stage_mem_read", 32'(bus.stage), 32'd1);
        check("alu_operand_0", bus.alu_operand_0, exp0);
        check("alu_operand_1", bus.alu_operand_1, exp1);
        check("mem_addr", bus.mem_addr, exp0);
        check("mem_write_data", bus.mem_write_data, exp1);
        if (nread > 0) begin
            for (int i = 0; i < nread; i++) begin
                check("mem_read_req_hi", 32'(bus.mem_read_req), 32'd1);
                check("stage_stall", 32'(bus.stage), 32'd1);
                if (i == nread - 1) begin
                    bus.mem_read_valid = 1'b1;
                    bus.mem_read_data  = rdata;
                end
                @(negedge clk);
                cyc++;
            end
            bus.mem_read_valid = 1'b0;
            bus.mem_read_data  = '0;
        end else begin
            check("mem_read_req_lo", 32'(bus.mem_read_req), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("stage_reg_update", 32'(bus.stage), 32'd2);
        check("wb_en", 32'(bus.wb_en), 32'(exp_wb));
        check("mem_read_req_off", 32'(bus.mem_read_req), 32'd0);
        @(negedge clk);
        cyc++;
        check("stage_mem_write", 32'(bus.stage), 32'd3);
        check("mem_write_req", 32'(bus.mem_write_req), 32'(exp_st));
        @(negedge clk);
        cyc++;
        check("stage_pc_update", 32'(bus.stage), 32'd4);
        check("done", 32'(bus.done), 32'd1);
        check("done_cycle", 32'(cyc), 32'(exp_done));
        @(negedge clk);
        check("done_off", 32'(bus.done), 32'd0);
    endtask

    task automatic read_regs(input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        run_instr(5'd0, '0, a, b, '0, '0, ea, eb, 0, 0, 0, '0, 4);
    endtask

    task automatic dump_all_zero();
        for (int i = 0; i < 16; i++) begin
            read_regs(AW'(2 * i), AW'(2 * i + 1), '0, '0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid    = 1'b0;
        bus.instr_type     = '0;
        bus.rd             = '0;
        bus.rs0            = '0;
        bus.rs1            = '0;
        bus.imm            = '0;
        bus.alu_result     = '0;
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = '0;
        #12;
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_stage", 32'(bus.stage), 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        dump_all_zero();

        // Load-immediate, then ALU reading it back.
        wb_q.push_back({5'd3, 32'hDEADBEEF});
        run_instr(5'd1, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1, 0, 0, '0, 4);
        wb_q.push_back({5'd4, 32'h12345678});
        run_instr(5'd5, 5'd4, 5'd3, 5'd0, 32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0,
                  1, 0, 0, '0, 4);

        wb_q.push_back({5'd5, 32'h40});
        run_instr(5'd1, 5'd5, 5'd0, 5'd0, 32'h40, 32'h0, 32'h0, 32'h0, 1, 0, 0, '0, 4);
        wb_q.push_back({5'd1, 32'h10});
        run_instr(5'd1, 5'd1, 5'd0, 5'd0, 32'h10, 32'h0, 32'h0, 32'h0, 1, 0, 0, '0, 4);
        wb_q.push_back({5'd2, 32'h77});
        run_instr(5'd1, 5'd2, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 32'h0, 1, 0, 0, '0, 4);

        // Load with three mem_read_req cycles; done lands on cycle 6.
        wb_q.push_back({5'd6, 32'hA5A5A5A5});
        run_instr(5'd2, 5'd6, 5'd5, 5'd4, 32'h0, 32'h0, 32'h40, 32'h12345678,
                  1, 0, 3, 32'hA5A5A5A5, 6);
        read_regs(5'd6, 5'd4, 32'hA5A5A5A5, 32'h12345678);

        // Store, then write to the zero register.
        st_q.push_back({32'h10, 32'h77});
        run_instr(5'd3, 5'd9, 5'd1, 5'd2, 32'h0, 32'h0, 32'h10, 32'h77, 0, 1, 0, '0, 4);
        wb_q.push_back({5'd0, 32'h5});
        run_instr(5'd1, 5'd0, 5'd0, 5'd0, 32'h5, 32'h0, 32'h0, 32'h0, 1, 0, 0, '0, 4);
        read_regs(5'd0, 5'd3, 32'h0, 32'hDEADBEEF);

        // Unsupported type behaves as a no-op.
        run_instr(5'd7, 5'd8, 5'd3, 5'd1, 32'h99, 32'h55, 32'hDEADBEEF, 32'h10, 0, 0, 0, '0, 4);
        read_regs(5'd8, 5'd2, 32'h0, 32'h77);

        // Reset during a stalled load aborts it and clears the array.
        @(negedge clk);
        bus.instr_type  = 5'd2;
        bus.rd          = 5'd7;
        bus.rs0         = 5'd1;
        bus.rs1         = 5'd2;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("abort_req_1", 32'(bus.mem_read_req), 32'd1);
        @(negedge clk);
        check("abort_req_2", 32'(bus.mem_read_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_stage", 32'(bus.stage), 32'd0);
        check("abort_req_off", 32'(bus.mem_read_req), 32'd0);
        check("abort_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_operand", bus.alu_operand_0, 32'd0);
        bus.mem_read_valid = 1'b1;
        bus.mem_read_data  = 32'hBAD0BAD0;
        @(negedge clk);
        @(negedge clk);
        bus.mem_read_valid = 1'b0;
        rst = 1'b0;

        dump_all_zero();

        check("wb_q_empty", 32'(wb_q.size()), 32'd0);
        check("st_q_empty", 32'(st_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/regfile_stage_controller.md
# regfile_stage_controller

Parametrised register file with an integrated five-stage instruction sequencer for the TinyCPU datapath. It stores the architectural registers and steps each accepted instruction through fetch, memory-read, register-update, memory-write and PC-update stages. It drives the operand, memory-request and write-back signals for no-op, load-immediate, load, store and ALU instructions. Unlike the previous combinational control, it owns the stage state, stalls on memory reads, and supports configurable width, depth and a hardwired zero register.

## Interface
- DATA_WIDTH, 32, register and data-bus width
- NUM_REGS, 32, register count; power of two, at least 2; REG_AW = log2(NUM_REGS) is derived
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are dropped

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction fields valid
- instr_ready  out  1  high exactly when stage == FETCH
- instr_type  in  5  0 no-op, 1 load-imm, 2 load, 3 store, 5 ALU; all other codes behave as no-op
- rd, rs0, rs1  in  REG_AW  destination and source register indices
- imm  in  DATA_WIDTH  load-immediate value
- alu_operand_0, alu_operand_1  out  DATA_WIDTH  latched rs0 and rs1 values
- alu_result  in  DATA_WIDTH  ALU output, sampled in REG_UPDATE
- mem_addr  out  DATA_WIDTH  latched rs0 value
- mem_read_req  out  1  load read request
- mem_read_valid  in  1  read data valid
- mem_read_data  in  DATA_WIDTH  read data
- mem_write_req  out  1  store strobe
- mem_write_data  out  DATA_WIDTH  latched rs1 value
- wb_en  out  1  register write this cycle
- wb_addr  out  REG_AW  register write index
- wb_data  out  DATA_WIDTH  register write data
- stage  out  3  0 FETCH, 1 MEM_READ, 2 REG_UPDATE, 3 MEM_WRITE, 4 PC_UPDATE
- done  out  1  one-cycle pulse in PC_UPDATE

## Operation
- **FETCH:** when instr_valid is high, the block accepts the instruction.
  - Captures instr_type, rd and imm.
  - Reads array[rs0] and array[rs1] into the operand registers; ZERO_REG applies to these reads.
  - Moves to MEM_READ. Without instr_valid it stays in FETCH.
- **MEM_READ:**
  - Load: mem_read_req is high. The block stays in MEM_READ until mem_read_valid, then captures mem_read_data into the load buffer and moves to REG_UPDATE.
  - All other types: one cycle; mem_read_req stays low and mem_read_valid is ignored.
- **REG_UPDATE:** one cycle.
  - wb_en = 1 for load-imm, load and ALU; otherwise 0.
  - wb_data is imm, the load buffer or alu_result, respectively; wb_addr = rd.
  - The array is written at the end of the cycle. When ZERO_REG = 1 and rd = 0, wb_en still pulses but the array is unchanged.
- **MEM_WRITE:** one cycle; mem_write_req = 1 only for store.
- **PC_UPDATE:** one cycle; done = 1; next stage is FETCH.
- Operand outputs (alu_operand_*, mem_addr, mem_write_data) hold their latched values from acceptance until the next acceptance.
- No write-to-read forwarding is needed: instructions are strictly sequential.
- All arithmetic is width-exact. The block performs no extension or truncation.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - stage = FETCH; every array entry, operand register, captured field and load buffer = 0.
  - All outputs are 0 except instr_ready = 1.
- **Reset mid-instruction:** the instruction is aborted and no write-back or memory request occurs after reset asserts.
- **Latency:** acceptance occurs in cycle 0. Load waits add cycles W ≥ 0, counted as cycles with mem_read_req high before mem_read_valid.
  - REG_UPDATE: cycle 2+W
  - MEM_WRITE: cycle 3+W
  - done: cycle 4+W
  - instr_ready: cycle 5+W
- **Throughput:** one instruction per 5+W cycles.
- **Output timing:** wb_en, mem_read_req, mem_write_req and done are decoded from registered state only, with no combinational path from inputs. instr_ready likewise depends on stage alone.
- **Inputs outside their stage are ignored:**
  - instr_valid outside FETCH
  - mem_read_valid outside a load in MEM_READ
  - alu_result outside REG_UPDATE

## Test plan
- **Reset defaults:** after reset, read all registers via ALU operand latching → every value is 0; instr_ready = 1; stage = 0.
- **Load-immediate then ALU:**
  - Load-imm rd=3, imm=0xDEADBEEF → wb_en in cycle 2 with wb_addr=3.
  - Then ALU rs0=3, rs1=0, rd=4, alu_result=0x12345678 → alu_operand_0 = 0xDEADBEEF, alu_operand_1 = 0, and register 4 is written.
- **Load with a 3-cycle stall:**
  - rs0 holds 0x40; mem_read_valid arrives on the 3rd MEM_READ cycle with data 0xA5A5A5A5.
  - Required: mem_addr = 0x40; mem_read_req high for 3 cycles; done at cycle 6; register rd = 0xA5A5A5A5.
- **Store and zero register:**
  - Store rs0=1 (0x10), rs1=2 (0x77) → mem_write_req for exactly one cycle in MEM_WRITE, with mem_addr = 0x10 and mem_write_data = 0x77.
  - Load-imm rd=0, imm=5 → register 0 still reads 0.
- **Invalid type and reset abort:**
  - instr_type=7 → 5-cycle pass with no wb_en, mem_read_req or mem_write_req.
  - Assert rst during a stalled load → no write occurs; stage = 0 immediately; all registers = 0.
